// File: rtl/cr_cceip_64_support_df_arb.sv
// Data-flow arbiter between the compression path (src0) and the bypass path (src1).
// A grant lasts one whole frame, and there is one idle bubble between frames.
module cr_cceip_64_support_df_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        src0_tvalid,
  input  logic        src0_tlast,
  input  logic        src1_tvalid,
  input  logic        src1_tlast,
  input  logic        ob_tready,
  input  logic [1:0]  arb_mode,
  input  logic        halt,
  output logic        df_mux_sel,
  output logic [1:0]  src_en,
  output logic [15:0] frm_cnt0,
  output logic [15:0] frm_cnt1,
  output logic        arb_idle
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        last_gnt_reg, last_gnt_next;
  logic        df_mux_sel_reg, df_mux_sel_next;
  logic [1:0]  src_en_reg, src_en_next;
  logic        arb_idle_reg, arb_idle_next;
  logic [1:0]  frm_done;
  logic        req0, req1;
  logic [15:0] frm_cnt_arr [2];

  assign req0 = src0_tvalid & ~halt;
  assign req1 = src1_tvalid & ~halt;

  always_comb begin
    state_next    = state_reg;
    last_gnt_next = last_gnt_reg;
    frm_done      = 2'b00;
    case (state_reg)
      IDLE: begin
        case (arb_mode)
          2'd1: if (req0) state_next = GNT0;
          2'd2: if (req1) state_next = GNT1;
          default: begin
            // Contention goes to whichever source was not granted last.
            if (req0 && req1)
              state_next = last_gnt_reg ? GNT0 : GNT1;
            else if (req0)
              state_next = GNT0;
            else if (req1)
              state_next = GNT1;
          end
        endcase
        if (state_next == GNT0) last_gnt_next = 1'b0;
        if (state_next == GNT1) last_gnt_next = 1'b1;
      end
      GNT0: begin
        if (src0_tvalid && ob_tready && src0_tlast) begin
          state_next  = IDLE;
          frm_done[0] = 1'b1;
        end
      end
      GNT1: begin
        if (src1_tvalid && ob_tready && src1_tlast) begin
          state_next  = IDLE;
          frm_done[1] = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered copies of the next state, giving a one-cycle grant latency.
  always_comb begin
    src_en_next     = {state_next == GNT1, state_next == GNT0};
    df_mux_sel_next = df_mux_sel_reg;
    if (state_next == GNT0) df_mux_sel_next = 1'b0;
    if (state_next == GNT1) df_mux_sel_next = 1'b1;
    arb_idle_next   = (state_next == IDLE) & ~src0_tvalid & ~src1_tvalid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_gnt_reg   <= 1'b0;
      df_mux_sel_reg <= 1'b0;
      src_en_reg     <= 2'b00;
      arb_idle_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_gnt_reg   <= last_gnt_next;
      df_mux_sel_reg <= df_mux_sel_next;
      src_en_reg     <= src_en_next;
      arb_idle_reg   <= arb_idle_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [15:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt_reg <= 16'd0;
        else if (frm_done[gi])
          cnt_reg <= cnt_reg + 16'd1;
      end
      assign frm_cnt_arr[gi] = cnt_reg;
    end
  endgenerate

  assign df_mux_sel = df_mux_sel_reg;
  assign src_en     = src_en_reg;
  assign frm_cnt0   = frm_cnt_arr[0];
  assign frm_cnt1   = frm_cnt_arr[1];
  assign arb_idle   = arb_idle_reg;

endmodule

// File: doc/cr_cceip_64_support_df_arb.md
CR_CCEIP_64_SUPPORT_DF_ARB -- requirements
Module: cr_cceip_64_support_df_arb

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port src0_tvalid, input, 1, tvalid of compression-path stream (crcg0 side).
REQ-004 SHALL have port src0_tlast, input, 1, tlast of src0.
REQ-005 SHALL have port src1_tvalid, input, 1, tvalid of bypass-path stream (crcc1 side).
REQ-006 SHALL have port src1_tlast, input, 1, tlast of src1.
REQ-007 SHALL have port ob_tready, input, 1, downstream tready after the data-flow mux.
REQ-008 SHALL have port arb_mode, input, 2, 0 = round-robin, 1 = force src0, 2 = force src1, 3 = treated as 0.
REQ-009 SHALL have port halt, input, 1, blocks new grants (driven from sup_osf_halt).
REQ-010 SHALL have port df_mux_sel, output, 1, registered mux select (0 = src0, 1 = src1).
REQ-011 SHALL have port src_en, output, 2, registered one-hot pass enable per source; 2'b00 when no grant.
REQ-012 SHALL have port frm_cnt0, output, 16, completed src0 frames.
REQ-013 SHALL have port frm_cnt1, output, 16, completed src1 frames.
REQ-014 SHALL have port arb_idle, output, 1, registered; 1 when in IDLE with no source valid.

Function
REQ-015 SHALL implement states IDLE, GNT0, GNT1; transfer beat xfer = granted source tvalid & ob_tready.
REQ-016 SHALL in IDLE compute req0 = src0_tvalid & ~halt, req1 = src1_tvalid & ~halt.
REQ-017 SHALL in IDLE with mode 1 go to GNT0 on req0 only; with mode 2 go to GNT1 on req1 only.
REQ-018 SHALL in IDLE with round-robin grant the sole requester, or on req0 & req1 the source not equal to last_gnt.
REQ-019 SHALL update last_gnt (1 bit, reset 0) on every IDLE->GNTx transition, to x.
REQ-020 SHALL have grant latency of exactly 1 cycle: request sampled at cycle N, df_mux_sel/src_en valid at N+1.
REQ-021 SHALL hold df_mux_sel constant for the whole frame; GNTx exits only on xfer with srcx_tlast.
REQ-022 SHALL on exit beat go to IDLE at next edge and increment frm_cntx by 1, wrapping 16'hFFFF -> 0.
REQ-023 SHALL insert exactly one IDLE cycle between frames (src_en = 2'b00 in that cycle).
REQ-024 SHALL retain df_mux_sel at its last value in IDLE; src_en carries the blocking.
REQ-025 SHALL ignore halt and arb_mode inside GNTx; in-flight frame always completes.
REQ-026 SHALL treat a changed arb_mode as effective at the next IDLE evaluation.
REQ-027 SHALL not count a tlast beat on a non-granted source, nor any beat with ob_tready = 0.
REQ-028 SHALL drive arb_idle <= (next state is IDLE) & ~src0_tvalid & ~src1_tvalid.

Reset
REQ-029 SHALL on rst_n low set state IDLE, df_mux_sel 0, src_en 2'b00, frm_cnt0/1 0, last_gnt 0, arb_idle 0.
REQ-030 SHALL on reset mid-frame abandon the frame without counting it; first post-reset grant follows REQ-018.

Verification
REQ-031 SHALL cover: src0_tvalid=1 only, mode 0, 3-beat frame, ob_tready=1 -> src_en=01 one cycle later, frm_cnt0=1, IDLE bubble, df_mux_sel=0.
REQ-032 SHALL cover: both valid continuously, mode 0, 1-beat frames -> grants alternate 1,0,1,0 (last_gnt=0 after reset), frm_cnt0=frm_cnt1 +/- 1.
REQ-033 SHALL cover: mode 2, only src0 valid -> src_en stays 00, frm_cnt0 stays 0, arb_idle=0.
REQ-034 SHALL cover: halt asserted mid-GNT1 frame -> frame completes, frm_cnt1 increments, no further grant while halt=1.
REQ-035 SHALL cover: ob_tready=0 on tlast beat for 4 cycles -> state held GNTx, counter unchanged until ready beat.
REQ-036 SHALL cover: frm_cnt0 preloaded to 16'hFFFF by 65535 frames, one more frame -> frm_cnt0=0; rst_n pulse mid-frame -> all outputs to REQ-029 values.
